// File: rtl/alu_pkg.sv
// Shared types for the 8-bit ALU issue path: operand widths, op codes and the
// decoded-op bundle passed from decode into the EX register.
package alu_pkg;

    localparam int unsigned W    = 8;
    localparam int unsigned RD_W = 3;

    typedef logic [1:0] scode_t;
    typedef logic [2:0] acode_t;

    typedef struct packed {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic            is_shift;
        scode_t          scode;
        acode_t          acode;
        logic            update_z_c;
        logic            use_carry;
        logic [RD_W-1:0] rd;
        logic            we;
    } ex_op_t;

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural Z/C flag register with update enable; also gates the C flag
// onto the ALU carry input for ops that consume it.
module alu_flag_reg (
    input  logic clk,
    input  logic rst,
    input  logic upd_en,
    input  logic z_in,
    input  logic c_in,
    input  logic use_carry,
    output logic flag_z,
    output logic flag_c,
    output logic carry_in
);

    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;

    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (upd_en) begin
            flag_z_d = z_in;
            flag_c_d = c_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;
    assign carry_in = use_carry & flag_c_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the combinational 8-bit ALU: EX register drives the ALU,
// WB register captures its result; valid/ready handshakes on both sides.
module alu_issue_ctrl
    import alu_pkg::ex_op_t;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned RD_W  = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [W-1:0]     id_a,
    input  logic [W-1:0]     id_b,
    input  logic             id_is_shift,
    input  logic [1:0]       id_scode,
    input  logic [2:0]       id_acode,
    input  logic             id_update_z_c,
    input  logic             id_use_carry,
    input  logic [RD_W-1:0]  id_rd,
    input  logic             id_we,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic             alu_carry_in,
    output logic             alu_is_shift,
    output logic             alu_update_z_c,
    output logic [1:0]       alu_scode,
    output logic [2:0]       alu_acode,
    input  logic [W-1:0]     alu_r,
    input  logic             alu_zero,
    input  logic             alu_carry_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [W-1:0]     wb_data,
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_we,
    output logic             flag_z,
    output logic             flag_c,
    output logic [CNT_W-1:0] retired
);

    ex_op_t           ex_q, ex_d;
    logic             ex_valid_q, ex_valid_d;
    logic             wb_valid_q, wb_valid_d;
    logic [W-1:0]     wb_data_q, wb_data_d;
    logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic ex_adv;
    logic id_fire;
    logic commit;

    always_comb begin
        ex_adv   = ex_valid_q & (~wb_valid_q | wb_ready);
        id_ready = ~ex_valid_q | ex_adv;
        id_fire  = id_valid & id_ready & ~flush;
        commit   = ex_adv & ~flush;

        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (id_fire) begin
            ex_d.a          = id_a;
            ex_d.b          = id_b;
            ex_d.is_shift   = id_is_shift;
            ex_d.scode      = id_scode;
            ex_d.acode      = id_acode;
            ex_d.update_z_c = id_update_z_c;
            ex_d.use_carry  = id_use_carry;
            ex_d.rd         = id_rd;
            ex_d.we         = id_we;
            ex_valid_d      = 1'b1;
        end else if (ex_adv || flush) begin
            ex_valid_d = 1'b0;
        end

        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_we_d    = wb_we_q;
        retired_d  = retired_q;
        // A flushed EX op still frees EX, but the WB slot only drains if it is not refilled.
        if (commit) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_r;
            wb_rd_d    = ex_q.rd;
            wb_we_d    = ex_q.we;
            retired_d  = retired_q + CNT_W'(1);
        end else if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_we_q    <= 1'b0;
            retired_q  <= '0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
            retired_q  <= retired_d;
        end
    end

    alu_flag_reg u_flags (
        .clk       (clk),
        .rst       (rst),
        .upd_en    (commit & ex_q.update_z_c),
        .z_in      (alu_zero),
        .c_in      (alu_carry_out),
        .use_carry (ex_q.use_carry),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .carry_in  (alu_carry_in)
    );

    assign alu_a          = ex_q.a;
    assign alu_b          = ex_q.b;
    assign alu_is_shift   = ex_q.is_shift;
    assign alu_update_z_c = ex_q.update_z_c;
    assign alu_scode      = ex_q.scode;
    assign alu_acode      = ex_q.acode;

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign wb_we    = wb_we_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a stubbed combinational ALU.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_a, id_b;
    logic        id_is_shift;
    logic [1:0]  id_scode;
    logic [2:0]  id_acode;
    logic        id_update_z_c, id_use_carry;
    logic [2:0]  id_rd;
    logic        id_we;
    logic [7:0]  alu_a, alu_b;
    logic        alu_carry_in, alu_is_shift, alu_update_z_c;
    logic [1:0]  alu_scode;
    logic [2:0]  alu_acode;
    logic [7:0]  alu_r;
    logic        alu_zero, alu_carry_out;
    logic        wb_valid, wb_ready;
    logic [7:0]  wb_data;
    logic [2:0]  wb_rd;
    logic        wb_we;
    logic        flag_z, flag_c;
    logic [15:0] retired;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    alu_issue_ctrl #(.W(8), .RD_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_a(id_a), .id_b(id_b), .id_is_shift(id_is_shift),
        .id_scode(id_scode), .id_acode(id_acode),
        .id_update_z_c(id_update_z_c), .id_use_carry(id_use_carry),
        .id_rd(id_rd), .id_we(id_we),
        .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
        .alu_is_shift(alu_is_shift), .alu_update_z_c(alu_update_z_c),
        .alu_scode(alu_scode), .alu_acode(alu_acode),
        .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry_out(alu_carry_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
        .flag_z(flag_z), .flag_c(flag_c), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_op(input logic [7:0] a, input logic [7:0] b, input logic upd,
                          input logic uc, input logic [2:0] rd);
        id_valid      = 1'b1;
        id_a          = a;
        id_b          = b;
        id_is_shift   = 1'b0;
        id_scode      = 2'd0;
        id_acode      = 3'd0;
        id_update_z_c = upd;
        id_use_carry  = uc;
        id_rd         = rd;
        id_we         = 1'b1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_a = '0; id_b = '0; id_is_shift = 1'b0; id_scode = '0; id_acode = '0;
        id_update_z_c = 1'b0; id_use_carry = 1'b0; id_rd = '0; id_we = 1'b0;
        wb_ready = 1'b1;
        alu_r = 8'h5A; alu_zero = 1'b0; alu_carry_out = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        step();
        rst = 1'b0;

        // single op, latency and flag commit
        put_op(8'hE5, 8'h07, 1'b1, 1'b0, 3'd5);
        step();
        id_valid = 1'b0;
        chk("t1_alu_a", {24'd0, alu_a}, 32'hE5);
        chk("t1_alu_b", {24'd0, alu_b}, 32'h07);
        chk("t1_alu_upd", {31'd0, alu_update_z_c}, 32'd1);
        chk("t1_wb_early", {31'd0, wb_valid}, 32'd0);
        step();
        chk("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("t1_wb_data", {24'd0, wb_data}, 32'h5A);
        chk("t1_wb_rd", {29'd0, wb_rd}, 32'd5);
        chk("t1_flags", {30'd0, flag_z, flag_c}, 32'b01);
        chk("t1_retired", {16'd0, retired}, 32'd1);

        // no-update op keeps flags; following carry consumer sees C=1
        alu_r = 8'h11; alu_zero = 1'b1; alu_carry_out = 1'b0;
        put_op(8'h10, 8'h20, 1'b0, 1'b0, 3'd3);
        step();
        put_op(8'h30, 8'h40, 1'b0, 1'b1, 3'd4);
        step();
        id_valid = 1'b0;
        chk("t2_flags_hold", {30'd0, flag_z, flag_c}, 32'b01);
        chk("t2_wb_data", {24'd0, wb_data}, 32'h11);
        chk("t2_wb_rd", {29'd0, wb_rd}, 32'd3);
        chk("t2_carry_in", {31'd0, alu_carry_in}, 32'd1);
        step();
        chk("t2_retired", {16'd0, retired}, 32'd3);
        step();
        chk("t2_drained", {31'd0, wb_valid}, 32'd0);

        // back-pressure: two ops, WB stalled
        wb_ready = 1'b0;
        alu_r = 8'hA1;
        put_op(8'h01, 8'h00, 1'b0, 1'b0, 3'd1);
        step();
        put_op(8'h02, 8'h00, 1'b0, 1'b0, 3'd2);
        step();
        put_op(8'h03, 8'h00, 1'b0, 1'b0, 3'd6);
        alu_r = 8'hB2;
        chk("t3_id_ready_lo", {31'd0, id_ready}, 32'd0);
        chk("t3_alu_a_b", {24'd0, alu_a}, 32'h02);
        step();
        step();
        chk("t3_alu_a_stable", {24'd0, alu_a}, 32'h02);
        chk("t3_wb_data_a", {24'd0, wb_data}, 32'hA1);
        chk("t3_wb_rd_a", {29'd0, wb_rd}, 32'd1);
        chk("t3_retired_mid", {16'd0, retired}, 32'd4);
        id_valid = 1'b0;
        wb_ready = 1'b1;
        step();
        chk("t3_wb_valid_b", {31'd0, wb_valid}, 32'd1);
        chk("t3_wb_data_b", {24'd0, wb_data}, 32'hB2);
        chk("t3_wb_rd_b", {29'd0, wb_rd}, 32'd2);
        chk("t3_retired", {16'd0, retired}, 32'd5);
        step();
        chk("t3_drained", {31'd0, wb_valid}, 32'd0);

        // flush kills EX op and drops the same-cycle decode op
        alu_r = 8'h5A; alu_zero = 1'b1; alu_carry_out = 1'b1;
        put_op(8'h44, 8'h00, 1'b1, 1'b0, 3'd7);
        step();
        put_op(8'h77, 8'h00, 1'b1, 1'b0, 3'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        chk("t4_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("t4_flags", {30'd0, flag_z, flag_c}, 32'b01);
        chk("t4_retired", {16'd0, retired}, 32'd5);
        chk("t4_dropped", {24'd0, alu_a}, 32'h44);
        step();
        chk("t4_still_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("t4_retired_late", {16'd0, retired}, 32'd5);

        // flag capture, then async reset during a stall
        alu_zero = 1'b1; alu_carry_out = 1'b0;
        put_op(8'h55, 8'h00, 1'b1, 1'b0, 3'd2);
        step();
        id_valid = 1'b0;
        wb_ready = 1'b0;
        step();
        chk("t5_flags_set", {30'd0, flag_z, flag_c}, 32'b10);
        put_op(8'h66, 8'h00, 1'b1, 1'b0, 3'd2);
        step();
        id_valid = 1'b0;
        chk("t5_stalled", {31'd0, id_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_wb", {31'd0, wb_valid}, 32'd0);
        chk("t5_rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
        chk("t5_rst_retired", {16'd0, retired}, 32'd0);
        chk("t5_rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("t5_rst_wb_data", {24'd0, wb_data}, 32'd0);
        chk("t5_rst_id_ready", {31'd0, id_ready}, 32'd1);
        step();
        rst = 1'b0;
        wb_ready = 1'b1;

        // counter wrap
        put_op(8'h01, 8'h01, 1'b0, 1'b0, 3'd0);
        for (int unsigned i = 0; i < 65536; i++) step();
        id_valid = 1'b0;
        chk("t6_retired_max", {16'd0, retired}, 32'hFFFF);
        step();
        chk("t6_retired_wrap", {16'd0, retired}, 32'd0);
        chk("t6_wb_valid", {31'd0, wb_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 8-bit ALU interface. The ALU is purely combinational.
- Registers decoded ops into an EX register, drives the ALU's operand, control and carry_in inputs, and captures R/zero/carry_out into a WB register.
- Owns the architectural Z/C flag register, updated only when the op's update_z_c is set.
- Sits between decode and register-file writeback, with valid/ready handshakes on both sides.

Parameters:
- W, 8, operand/result width (matches the ALU datapath).
- RD_W, 3, destination register index width.
- CNT_W, 16, retired-op counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill the op in EX and any op presented by decode this cycle.
- id_valid  in  1  decode presents an op.
- id_ready  out  1  EX register can accept the op.
- id_a  in  W  operand A.
- id_b  in  W  operand B (shift amount when shifting).
- id_is_shift  in  1  shift-class op.
- id_scode  in  2  shift code.
- id_acode  in  3  arithmetic/logic code.
- id_update_z_c  in  1  op commits Z/C.
- id_use_carry  in  1  op consumes the C flag as carry_in.
- id_rd  in  RD_W  destination register.
- id_we  in  1  op writes the register file.
- alu_a, alu_b  out  W  to ALU.
- alu_carry_in  out  1  to ALU.
- alu_is_shift  out  1  to ALU.
- alu_update_z_c  out  1  to ALU.
- alu_scode  out  2  to ALU.
- alu_acode  out  3  to ALU.
- alu_r  in  W  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_carry_out  in  1  ALU carry flag.
- wb_valid  out  1  WB register holds a result.
- wb_ready  in  1  writeback consumes the result.
- wb_data  out  W  captured alu_r.
- wb_rd  out  RD_W  destination register.
- wb_we  out  1  write enable for the result.
- flag_z, flag_c  out  1  architectural flags.
- retired  out  CNT_W  count of ops moved EX->WB.

Behaviour:
- Reset (async, immediate):
  - ex_valid=0, wb_valid=0, flag_z=0, flag_c=0, retired=0.
  - All EX/WB payload registers = 0, so all alu_* outputs are 0.
  - wb_data=0, wb_rd=0, wb_we=0.
- Two-stage pipeline. ALU outputs are sampled in the same cycle the EX register drives them.
- Latency: id handshake at edge N -> wb_valid=1 after edge N+1, given no back-pressure.
- Definitions:
  - ex_adv = ex_valid & (~wb_valid | wb_ready).
  - id_ready = ~ex_valid | ex_adv (combinational; does not depend on id_valid).
  - id_fire = id_valid & id_ready & ~flush.
- EX register load:
  - On id_fire, load all id_* fields and set ex_valid=1.
  - Else if ex_adv or flush, set ex_valid=0.
  - Else hold.
- ALU drive: the alu_* outputs always reflect the EX register, except alu_carry_in = ex_use_carry & flag_c.
- On ex_adv & ~flush:
  - WB register <= {alu_r, ex_rd, ex_we}, wb_valid=1.
  - retired += 1, wrapping modulo 2^CNT_W.
  - If ex_update_z_c, flag_z <= alu_zero and flag_c <= alu_carry_out.
- WB drain: if wb_valid & wb_ready and there is no ex_adv, set wb_valid=0. Simultaneous drain and refill keeps wb_valid=1 with the new data.
- Flag hazard: the flag update happens on the same edge the next op enters EX, so back-to-back carry chains see the updated C with no stall.
- Flush:
  - Kills the EX op: no WB capture, no flag update, no count.
  - Drops a same-cycle id op: id_fire=0, even though id_ready may read 1.
  - WB contents are unaffected.
- Back-pressure: with wb_valid=1 and wb_ready=0, EX holds and the alu_* outputs are stable. A second op stalls with id_ready=0.
- Reset mid-operation: all in-flight ops are lost and flags clear. No partial writeback.

Decomposition:
- Package alu_pkg holds:
  - W and RD_W constants.
  - Typedefs scode_t[1:0] and acode_t[2:0].
  - Struct ex_op_t {a, b, is_shift, scode, acode, update_z_c, use_carry, rd, we}, shared with decode.
- Natural sub-module: alu_flag_reg, the Z/C register with update enable and carry_in gating.
- The EX/WB handshake logic stays in the top.

Test Plan (bench stubs the ALU: alu_r=0x5A, zero=0, carry_out=1 unless noted):
- Reset, then one op {a=0xE5, b=0x07, acode=0, update_z_c=1} -> alu_a=0xE5/alu_b=0x07 in the cycle after accept; next cycle wb_valid=1, wb_data=0x5A; flag_c=1, flag_z=0; retired=1.
- Op with update_z_c=0 after the previous test -> flags hold (Z=0, C=1); the following op with use_carry=1 drives alu_carry_in=1.
- wb_ready=0 for 3 cycles with 2 ops issued -> second op holds in EX, id_ready=0, alu_* stable; on release both retire in order, retired=+2.
- flush asserted while EX holds an op with update_z_c=1 (stub zero=1) -> no wb_valid, flag_z unchanged, retired unchanged; a same-cycle id_valid op is dropped.
- Stub returns zero=1, carry_out=0 with update_z_c=1, then rst asserted mid-stall -> outputs clear immediately without a clock edge; flags=0, wb_valid=0.
- 65536 retired ops -> retired wraps to 0.
